// File: rtl/smi_pkg.sv
// Shared constants and types for the SMI transmit packer: IOC register map,
// default version value and the enable FSM state type.
package smi_pkg;

  localparam logic [7:0] DEFAULT_MODULE_VERSION = 8'h01;

  localparam logic [4:0] IOC_VERSION      = 5'd0;
  localparam logic [4:0] IOC_STATUS       = 5'd1;
  localparam logic [4:0] IOC_CONTROL      = 5'd2;
  localparam logic [4:0] IOC_WORD_COUNT   = 5'd3;
  localparam logic [4:0] IOC_FIRST_UNUSED = 5'd4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/smi_sync.sv
// Multi-flop synchronizer for one asynchronous SMI control line, with a
// single-cycle rising-edge indication on the synchronized level.
module smi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              last;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop in the chain samples its predecessor's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      last  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      last  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~last;

endmodule

// File: rtl/smi_tx_packer.sv
// SMI TX front end: packs RPI-written bytes MSB-first into 32-bit words for
// the TX FIFO and exposes version/status/control/word-count IOC registers.
module smi_tx_packer
  import smi_pkg::*;
#(
  parameter logic [7:0] MODULE_VERSION = DEFAULT_MODULE_VERSION,
  parameter int         SYNC_STAGES    = 2
) (
  input  logic        i_sys_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_ioc,
  input  logic [7:0]  i_data_in,
  output logic [7:0]  o_data_out,
  input  logic        i_cs,
  input  logic        i_fetch_cmd,
  input  logic        i_load_cmd,
  input  logic [2:0]  i_smi_a,
  input  logic        i_smi_swe_srw,
  input  logic [7:0]  i_smi_data_in,
  output logic        o_smi_write_req,
  output logic        o_fifo_push,
  output logic [31:0] o_fifo_pushed_data,
  input  logic        i_fifo_full,
  output logic        o_overflow,
  output logic        o_address_error
);

  state_t      state, next_state;
  logic [1:0]  byte_idx;
  logic [31:0] assembly;
  logic [7:0]  word_count;
  logic [7:0]  data_dly [SYNC_STAGES];
  logic        swe_rise, swe_level_unused;
  logic        a1_level, a1_rise;
  logic        smi_a_unused;

  assign smi_a_unused = ^{i_smi_a[2], i_smi_a[0]};

  smi_sync #(.STAGES(SYNC_STAGES)) u_swe_sync (
    .clk (i_sys_clk),
    .rst (i_rst),
    .d   (i_smi_swe_srw),
    .q   (swe_level_unused),
    .rise(swe_rise)
  );

  smi_sync #(.STAGES(SYNC_STAGES)) u_a1_sync (
    .clk (i_sys_clk),
    .rst (i_rst),
    .d   (i_smi_a[1]),
    .q   (a1_level),
    .rise(a1_rise)
  );

  // Data delay matches the strobe synchronizer so the byte lines up with swe_rise.
  // NOTE: this delay line is a few flops rather than a RAM, so it is reset like any other state.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) data_dly[i] <= '0;
    end else begin
      data_dly[0] <= i_smi_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) data_dly[i] <= data_dly[i-1];
    end
  end

  logic reg_rd, reg_wr, ctrl_wr, realign, clear_word, capture, last_byte;
  logic [7:0] smi_byte;

  assign smi_byte   = data_dly[SYNC_STAGES-1];
  assign reg_rd     = i_cs & i_fetch_cmd;
  assign reg_wr     = i_cs & i_load_cmd;
  assign ctrl_wr    = reg_wr && (i_ioc == IOC_CONTROL);
  assign realign    = ctrl_wr && i_data_in[1];
  // A state change, realign or TX->RX turnaround discards any partial word; disable beats a capture.
  assign clear_word = (next_state != state) || realign || a1_rise;
  assign capture    = swe_rise && !a1_level && (state == ST_COLLECT) && !clear_word;
  assign last_byte  = capture && (byte_idx == 2'd3);

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state is defaulted first so no path through the block infers a latch.
  always_comb begin
    next_state = state;
    if (ctrl_wr) next_state = i_data_in[0] ? ST_COLLECT : ST_IDLE;
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      byte_idx           <= '0;
      assembly           <= '0;
      word_count         <= '0;
      o_fifo_push        <= 1'b0;
      o_fifo_pushed_data <= '0;
      o_overflow         <= 1'b0;
      o_smi_write_req    <= 1'b0;
    end else begin
      o_fifo_push     <= 1'b0;
      o_smi_write_req <= (state == ST_COLLECT) && !i_fifo_full;
      // Overflow set has priority over a simultaneous clear.
      o_overflow      <= (o_overflow && !realign) || (last_byte && i_fifo_full);
      if (clear_word) begin
        byte_idx <= '0;
        assembly <= '0;
      end else if (last_byte) begin
        byte_idx           <= '0;
        assembly           <= '0;
        o_fifo_pushed_data <= {assembly[31:8], smi_byte};
        if (!i_fifo_full) begin
          o_fifo_push <= 1'b1;
          word_count  <= word_count + 8'd1;
        end
      end else if (capture) begin
        assembly[{~byte_idx, 3'b000} +: 8] <= smi_byte;
        byte_idx                           <= byte_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      o_data_out      <= '0;
      o_address_error <= 1'b0;
    end else begin
      o_address_error <= (reg_rd || reg_wr) && (i_ioc >= IOC_FIRST_UNUSED);
      if (reg_rd) begin
        case (i_ioc)
          IOC_VERSION:    o_data_out <= MODULE_VERSION;
          IOC_STATUS:     o_data_out <= {3'b000, byte_idx, i_fifo_full, o_overflow,
                                         state == ST_COLLECT};
          IOC_CONTROL:    o_data_out <= {7'b0000000, state == ST_COLLECT};
          IOC_WORD_COUNT: o_data_out <= word_count;
          default:        o_data_out <= o_data_out;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_smi_tx_packer.sv
// Randomized self-checking bench for smi_tx_packer against a byte-queue
// reference model of the packing, overflow and word-count rules.
module tb_smi_tx_packer;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ioc = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        cs = 1'b0, fetch_cmd = 1'b0, load_cmd = 1'b0;
  logic [2:0]  smi_a = '0;
  logic        swe = 1'b0;
  logic [7:0]  smi_data = '0;
  logic        write_req, push, overflow, address_error;
  logic [31:0] pushed_data;
  logic        fifo_full = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit          m_en = 0;
  bit          m_a1 = 0;
  bit          m_ovf = 0;
  logic [7:0]  m_count = 8'd0;
  logic [7:0]  m_bytes[$];
  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  int          aerr_pulses = 0;

  smi_tx_packer #(.MODULE_VERSION(8'h01), .SYNC_STAGES(SYNC)) dut (
    .i_sys_clk         (clk),
    .i_rst             (rst),
    .i_ioc             (ioc),
    .i_data_in         (data_in),
    .o_data_out        (data_out),
    .i_cs              (cs),
    .i_fetch_cmd       (fetch_cmd),
    .i_load_cmd        (load_cmd),
    .i_smi_a           (smi_a),
    .i_smi_swe_srw     (swe),
    .i_smi_data_in     (smi_data),
    .o_smi_write_req   (write_req),
    .o_fifo_push       (push),
    .o_fifo_pushed_data(pushed_data),
    .i_fifo_full       (fifo_full),
    .o_overflow        (overflow),
    .o_address_error   (address_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (push) got.push_back(pushed_data);
    if (address_error) aerr_pulses++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- model + drivers ----------------
  task automatic model_reset();
    m_en = 0; m_ovf = 0; m_count = 8'd0;
    m_bytes.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    if (m_en && !m_a1) begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
        w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        if (fifo_full) m_ovf = 1;
        else begin
          exp_q.push_back(w);
          m_count = m_count + 8'd1;
        end
        m_bytes.delete();
      end
    end
  endtask

  // Drives one SMI write strobe; lat = negedges from swe rise to push, or -1.
  task automatic smi_byte(input logic [7:0] b, output int lat);
    lat = -1;
    @(negedge clk); smi_data = b;
    @(negedge clk); swe = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (push && lat < 0) lat = n;
    end
    swe = 1'b0;
    repeat (3) @(negedge clk);
    model_byte(b);
  endtask

  task automatic set_a1(input bit v);
    if (v && !m_a1) m_bytes.delete();
    m_a1 = v;
    @(negedge clk); smi_a[1] = v;
    repeat (4) @(negedge clk);
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cs = 1; load_cmd = 1; ioc = a; data_in = d;
    @(posedge clk); #1;
    cs = 0; load_cmd = 0;
    if (a == 5'd2) begin
      if (bit'(d[0]) != m_en) m_bytes.delete();
      m_en = d[0];
      if (d[1]) begin m_ovf = 0; m_bytes.delete(); end
    end
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [7:0] d, output logic aerr);
    @(posedge clk); #1;
    cs = 1; fetch_cmd = 1; ioc = a;
    @(posedge clk); #1;
    cs = 0; fetch_cmd = 0;
    d = data_out;
    aerr = address_error;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] d; logic e;
    do_reset();
    checks++;
    if ({data_out, push, pushed_data, write_req, overflow, address_error} !== 45'd0) begin
      failures++;
      $display("FAIL reset_outputs: got dout=%h push=%b word=%h req=%b ovf=%b aerr=%b, want all 0",
               data_out, push, pushed_data, write_req, overflow, address_error);
    end
    rst = 0;
    reg_read(5'd0, d, e);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL version: got %h want 01", d); end
    reg_read(5'd1, d, e);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reset_status: got %h want 00", d); end
    reg_read(5'd3, d, e);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reset_count: got %h want 00", d); end
  endtask

  task automatic test_basic();
    logic [7:0] d; logic e; int lat;
    logic [7:0] bytes[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    reg_write(5'd2, 8'h01);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (write_req !== 1'b1) begin failures++; $display("FAIL write_req_enabled: got %b want 1", write_req); end
    for (int i = 0; i < 4; i++) begin
      smi_byte(bytes[i], lat);
      checks++;
      if (lat !== ((i == 3) ? SYNC + 1 : -1)) begin
        failures++;
        $display("FAIL push_latency byte%0d: got %0d want %0d", i, lat, (i == 3) ? SYNC + 1 : -1);
      end
    end
    checks++;
    if (got.size() != 1 || got[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_word: got %0d pushes first=%h want 1 push DEADBEEF",
               got.size(), (got.size() > 0) ? got[0] : 32'h0);
    end
    got.delete(); exp_q.delete();
    reg_read(5'd3, d, e);
    checks++;
    if (d !== m_count) begin failures++; $display("FAIL basic_count: got %h want %h", d, m_count); end
    reg_read(5'd1, d, e);
    checks++;
    if (d[4:3] !== 2'd0) begin failures++; $display("FAIL basic_index: got %0d want 0", d[4:3]); end
  endtask

  task automatic test_turnaround();
    logic [7:0] d; logic e; int lat;
    logic [7:0] bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    smi_byte(8'h55, lat);
    smi_byte(8'h66, lat);
    reg_read(5'd1, d, e);
    checks++;
    if (d[4:3] !== 2'd2) begin failures++; $display("FAIL partial_index: got %0d want 2", d[4:3]); end
    set_a1(1); set_a1(0);
    reg_read(5'd1, d, e);
    checks++;
    if (d[4:3] !== 2'd0) begin failures++; $display("FAIL turnaround_index: got %0d want 0", d[4:3]); end
    for (int i = 0; i < 4; i++) smi_byte(bytes[i], lat);
    checks++;
    if (got.size() != 1 || got[0] !== 32'h11223344) begin
      failures++;
      $display("FAIL turnaround_word: got %0d pushes first=%h want 1 push 11223344",
               got.size(), (got.size() > 0) ? got[0] : 32'h0);
    end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [7:0] d; logic e; int lat;
    fifo_full = 1;
    for (int i = 0; i < 4; i++) smi_byte(8'(i + 1), lat);
    checks++;
    if (got.size() != 0 || write_req !== 1'b0) begin
      failures++; $display("FAIL full_no_push: got %0d pushes req=%b want 0 pushes req=0", got.size(), write_req);
    end
    fifo_full = 0;
    reg_read(5'd1, d, e);
    checks++;
    if (d[1] !== 1'b1 || overflow !== 1'b1) begin
      failures++; $display("FAIL overflow_set: got status=%h pin=%b want bit1=1", d, overflow);
    end
    reg_write(5'd2, 8'h03);
    reg_read(5'd1, d, e);
    checks++;
    if (d[1:0] !== 2'b01) begin failures++; $display("FAIL overflow_clear: got status=%h want bits[1:0]=01", d); end
    reg_read(5'd2, d, e);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL control_read: got %h want 01", d); end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_ignored();
    logic [7:0] d; logic e; int lat;
    reg_write(5'd2, 8'h00);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (write_req !== 1'b0) begin failures++; $display("FAIL write_req_disabled: got %b want 0", write_req); end
    for (int i = 0; i < 5; i++) smi_byte(8'($urandom), lat);
    reg_write(5'd2, 8'h01);
    set_a1(1);
    for (int i = 0; i < 5; i++) smi_byte(8'($urandom), lat);
    set_a1(0);
    reg_read(5'd1, d, e);
    checks++;
    if (got.size() != 0 || d[4:3] !== 2'd0) begin
      failures++; $display("FAIL ignored_strobes: got %0d pushes index=%0d want 0 pushes index 0", got.size(), d[4:3]);
    end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] d; logic e; int lat;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin set_a1(1); set_a1(0); end
      fifo_full = ($urandom_range(0, 7) == 0);
      smi_byte(8'($urandom), lat);
    end
    fifo_full = 0;
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++; $display("FAIL random_push_count: got %0d want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin failures++; $display("FAIL random_word%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
    reg_read(5'd1, d, e);
    checks++;
    if (d[1] !== m_ovf || d[4:3] !== 2'(m_bytes.size())) begin
      failures++; $display("FAIL random_status: got ovf=%b idx=%0d want ovf=%b idx=%0d", d[1], d[4:3], m_ovf, m_bytes.size());
    end
    reg_read(5'd3, d, e);
    checks++;
    if (d !== m_count) begin failures++; $display("FAIL random_count: got %h want %h", d, m_count); end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_wrap_and_ioc();
    logic [7:0] d; logic e; int lat; int n;
    do_reset(); rst = 0;
    reg_write(5'd2, 8'h01);
    n = 0;
    do begin
      for (int i = 0; i < 4; i++) smi_byte(8'($urandom), lat);
      n++;
    end while (m_count != 8'd0 && n < 300);
    checks++;
    if (got.size() != 256 || exp_q.size() != 256) begin
      failures++; $display("FAIL wrap_push_count: got %0d model %0d want 256", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      if (got[i] !== exp_q[i]) begin
        checks++; failures++;
        $display("FAIL wrap_word%0d: got %h want %h", i, got[i], exp_q[i]);
        break;
      end
    end
    reg_read(5'd3, d, e);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL count_wrap: got %h want 00", d); end
    got.delete(); exp_q.delete();
    reg_write(5'd0, 8'hFF);
    reg_write(5'd3, 8'h55);
    reg_read(5'd0, d, e);
    aerr_pulses = 0;
    reg_read(5'd7, d, e);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (d !== 8'h01 || aerr_pulses != 1) begin
      failures++; $display("FAIL bad_ioc_fetch: got dout=%h pulses=%0d want dout=01 pulses=1", d, aerr_pulses);
    end
    reg_write(5'd9, 8'hAA);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (aerr_pulses != 2) begin failures++; $display("FAIL bad_ioc_load: got pulses=%0d want 2", aerr_pulses); end
    reg_read(5'd3, d, e);
    checks++;
    if (d !== 8'h00 || aerr_pulses != 2) begin
      failures++; $display("FAIL readonly_write: got count=%h pulses=%0d want 00 and 2", d, aerr_pulses);
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] d; logic e; int lat;
    logic [7:0] bytes[4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    smi_byte(8'hA1, lat);
    smi_byte(8'hB2, lat);
    reg_read(5'd0, d, e);
    do_reset();
    checks++;
    if ({data_out, push, pushed_data, write_req, overflow, address_error} !== 45'd0) begin
      failures++;
      $display("FAIL midword_reset_outputs: got dout=%h push=%b word=%h req=%b, want all 0",
               data_out, push, pushed_data, write_req);
    end
    rst = 0;
    reg_read(5'd1, d, e);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL midword_status: got %h want 00", d); end
    reg_write(5'd2, 8'h01);
    for (int i = 0; i < 4; i++) smi_byte(bytes[i], lat);
    checks++;
    if (got.size() != 1 || got[0] !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL midword_clean_word: got %0d pushes first=%h want 1 push CAFEF00D",
               got.size(), (got.size() > 0) ? got[0] : 32'h0);
    end
    got.delete(); exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_turnaround();
    test_overflow();
    test_ignored();
    test_random();
    test_wrap_and_ioc();
    test_reset_midword();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
